// File: rtl/chunked_serial_adder_pkg.sv
// Shared definitions for the chunked serial adder: FSM state encoding and
// the ceil(log2) helper used to size the chunk index counter.
package chunked_serial_adder_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Smallest r such that 2**r >= value (0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Start/busy/done handshake bundle for the chunked serial adder.
// Optional feature macro: SUB_MODE_EN adds the 'sub' request signal.
interface chunked_serial_adder_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carryInput;
`ifdef SUB_MODE_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carryOutput;
   logic             overflow;

`ifdef SUB_MODE_EN
   modport master (
      output start, a, b, carryInput, sub,
      input  busy, done, sum, carryOutput, overflow
   );
   modport slave (
      input  start, a, b, carryInput, sub,
      output busy, done, sum, carryOutput, overflow
   );
`else
   modport master (
      output start, a, b, carryInput,
      input  busy, done, sum, carryOutput, overflow
   );
   modport slave (
      input  start, a, b, carryInput,
      output busy, done, sum, carryOutput, overflow
   );
`endif

endinterface

// File: rtl/chunked_serial_adder_chunk_adder.sv
// CHUNK-bit ripple-carry stage built from FullAdder cells; purely
// combinational and reused every cycle by the serial adder.

// One-bit full adder cell.
module FullAdder (
   input  logic a,
   input  logic b,
   input  logic carryInput,
   output logic sum,
   output logic carryOutput
);

   assign sum         = a ^ b ^ carryInput;
   assign carryOutput = (a & b) | (carryInput & (a ^ b));

endmodule

module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             carryInput,
   output logic [CHUNK-1:0] sum,
   output logic             carryOutput
);

   logic [CHUNK:0] carry;

   assign carry[0] = carryInput;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      FullAdder u_fa (
         .a          (a[i]),
         .b          (b[i]),
         .carryInput (carry[i]),
         .sum        (sum[i]),
         .carryOutput(carry[i+1])
      );
   end

   assign carryOutput = carry[CHUNK];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder that processes CHUNK bits per clock through a
// single shared ripple-carry stage, carrying between chunks in a register.
// Handshake: start accepted when not busy (IDLE or DONE), done pulses once.
// Optional feature macro: SUB_MODE_EN enables subtract mode (a - b).
module chunked_serial_adder
   import chunked_serial_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   chunked_serial_adder_if.slave  bus
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (clog2(N) > 1) ? clog2(N) : 1;

   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
   end

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic               accept;
   logic               last_chunk;
   logic [CHUNK-1:0]   op_a;
   logic [CHUNK-1:0]   op_b;
   logic [CHUNK-1:0]   chunk_sum;
   logic               chunk_cout;

   // A request is taken whenever no computation is in flight.
   assign accept     = bus.start && (state_q != ST_RUN);
   assign last_chunk = (idx_q == IDX_W'(N - 1));

   // Select the current chunk of the latched operands.
   always_comb begin
      op_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
      op_b = b_q[int'(idx_q)*CHUNK +: CHUNK];
   end

   chunk_adder #(
      .CHUNK(CHUNK)
   ) u_chunk_adder (
      .a          (op_a),
      .b          (op_b),
      .carryInput (carry_q),
      .sum        (chunk_sum),
      .carryOutput(chunk_cout)
   );

   // State register; reset wins over any pending start.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   // NOTE: assign a default first in every always_comb so no path leaves a signal unassigned (latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (bus.start) state_d = ST_RUN;
         ST_RUN:  if (last_chunk) state_d = ST_DONE;
         ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs: handshake flags decoded from state, results from registers.
   always_comb begin
      bus.busy        = (state_q == ST_RUN);
      bus.done        = (state_q == ST_DONE);
      bus.sum         = sum_q;
      bus.carryOutput = cout_q;
      bus.overflow    = ovf_q;
   end

   // Datapath: latch operands on accept, fold one chunk per RUN cycle.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      if (accept) begin
         a_d     = bus.a;
         b_d     = bus.b;
         carry_d = bus.carryInput;
`ifdef SUB_MODE_EN
         // a - b as a + ~b + 1; carryOutput=1 then means no borrow.
         if (bus.sub) begin
            b_d     = ~bus.b;
            carry_d = 1'b1;
         end
`endif
         idx_d   = '0;
      end else if (state_q == ST_RUN) begin
         sum_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_sum;
         carry_d = chunk_cout;
         idx_d   = idx_q + IDX_W'(1);
         if (last_chunk) begin
            cout_d = chunk_cout;
            // Carry into the MSB is recovered from the MSB sum bit.
            ovf_d  = chunk_cout ^ (op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ chunk_sum[CHUNK-1]);
         end
      end
   end

   // Datapath registers; reset discards any partial result.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: doc/chunked_serial_adder.md
# chunked_serial_adder

Parametrised multi-cycle adder/subtractor that adds two WIDTH-bit operands CHUNK bits per clock. Carry is held in a register between chunks, so only one CHUNK-bit ripple-carry stage is instantiated and reused each cycle. It succeeds the fixed 8-bit ripple-carry adder in the arithmetic datapath wherever wide operands must not build a long combinational carry chain. It uses a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 32: operand and result width. Must be a positive multiple of CHUNK.
- CHUNK, 8: bits processed per cycle. 1 ≤ CHUNK ≤ WIDTH.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- a  input  WIDTH  operand A, sampled at accept.
- b  input  WIDTH  operand B, sampled at accept.
- carryInput  input  1  carry-in, sampled at accept.
- sub  input  1  subtract mode, sampled at accept (present only with SUB_MODE_EN).
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result, held until the next accept.
- carryOutput  output  1  carry out of bit WIDTH-1, held with sum.
- overflow  output  1  signed overflow, held with sum.

## Operation
- N = WIDTH/CHUNK chunks. The chunk index counter is max(1, clog2(N)) bits wide.
- FSM states:
  - IDLE: busy=0. On start, latch a, b, carryInput (and sub), clear idx, go to RUN.
  - RUN: busy=1. Each cycle, add chunk idx of the operand registers plus the carry register. Write the chunk sum into sum[idx*CHUNK +: CHUNK], update the carry register, increment idx. On the last chunk (idx = N-1), go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0. A start in this cycle is accepted and goes to RUN. Otherwise go to IDLE.
- Result semantics: {carryOutput, sum} = a + b + carryInput, modulo 2^(WIDTH+1).
- overflow = carry into MSB XOR carry out of MSB, captured on the last chunk.
- A start while busy=1 is ignored; no queueing.
- sum, carryOutput and overflow change only during RUN, and hold after DONE.
- Reset: all outputs go to 0 and the FSM goes to IDLE on the next edge, including mid-RUN. A partially computed sum is discarded and done is never raised for that request. rst has priority over start in the same cycle.

## Timing
- Accept at edge T0 (start=1, busy=0). RUN occupies edges T1..TN. done=1 during the cycle after TN.
- Latency: start to done is N+1 cycles. Throughput: one operation per N+1 cycles, with back-to-back start accepted in the DONE cycle.
- busy rises the cycle after accept and falls in the DONE cycle.
- Inputs a, b, carryInput and sub may change freely after accept.
- Reset values: busy=0, done=0, sum=0, carryOutput=0, overflow=0.

## Configuration
- SUB_MODE_EN defined:
  - The sub port exists.
  - sub=1 latches ~b and forces carry-in to 1, computing a - b; carryInput is ignored.
  - carryOutput=1 means no borrow.
- SUB_MODE_EN undefined: no sub port, add only.

## Structure
- Shared package: FSM state encoding (IDLE, RUN, DONE) as localparams, and the clog2 helper function.
- One sub-module: chunk_adder, a CHUNK-bit ripple-carry stage with ports a, b, carryInput, sum, carryOutput, built from the existing FullAdder cell. It is purely combinational and instantiated once.

## Test plan
- WIDTH=32, CHUNK=8; a=0xFFFFFFFF, b=0x00000001, carryInput=0 → done 5 cycles after start; sum=0, carryOutput=1, overflow=0.
- a=0x7FFFFFFF, b=1 → sum=0x80000000, overflow=1, carryOutput=0.
- SUB_MODE_EN, sub=1, a=5, b=7 → sum=0xFFFFFFFE, carryOutput=0. Then a=7, b=5 → sum=2, carryOutput=1.
- Start during RUN with different operands → ignored; first result is unchanged, and exactly one done pulse occurs. Back-to-back start in the DONE cycle → second result 5 cycles later.
- Assert rst at the 2nd RUN cycle → next cycle busy=0, sum=0, no done pulse. A new start then completes normally.
- WIDTH=CHUNK=8; a=0xC8, b=0x64, carryInput=1 → sum=0x2D, carryOutput=1, done 2 cycles after start.
